serial_subtractor: RTL and testbench

Bit-serial subtractor computing `A - B` LSB-first, one bit per clock, with a start/done handshake. It is the inverse-direction companion to the combinational adder blocks in the adders library. Its bit cell is built from half subtractors, and it reuses the same per-bit logic a half adder exercises. It sits as a low-area arithmetic unit next to the combinational adders, driven by a controller that issues one operation at a time.

---
 rtl/serial_subtractor_pkg.sv | 17 +
 rtl/serial_subtractor_half_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 114 +++++++++++
 tb/tb_serial_subtractor.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
// FSM encodings and the bit-counter width.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 8;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_half_subtractor.sv
// Combinational half subtractor: diff = A ^ B, borrow = ~A & B.
// Two of these plus an OR make one full-subtractor bit cell.
module half_subtractor (
  input  logic A,
  input  logic B,
  output logic diff,
  output logic borrow
);

  assign diff   = A ^ B;
  assign borrow = ~A & B;

endmodule

// File: rtl/serial_subtractor.sv
// LSB-first bit-serial subtractor computing A - B, one bit per clock.
// Result and borrow are published only when the last bit is done.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             bin_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;

  logic d0;
  logic br0;
  logic d_d;
  logic br1;
  logic bout_d;
  logic last;

  half_subtractor u_hs0 (
    .A      (a_q[0]),
    .B      (b_q[0]),
    .diff   (d0),
    .borrow (br0)
  );

  half_subtractor u_hs1 (
    .A      (d0),
    .B      (bin_q),
    .diff   (d_d),
    .borrow (br1)
  );

  assign bout_d = br0 | br1;
  assign last   = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      bin_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= ST_SHIFT;
            a_q     <= A;
            b_q     <= B;
            bin_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= {d_d, res_q[WIDTH-1:1]};
          bin_q <= bout_d;
          cnt_q <= cnt_q + CW'(1);
          // final bit: publish the assembled result in the same edge
          if (last) begin
            state_q  <= ST_DONE;
            diff_q   <= {d_d, res_q[WIDTH-1:1]};
            borrow_q <= bout_d;
            done_q   <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8)
// and the standalone half_subtractor cell.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;

  logic ha = 1'b0;
  logic hb = 1'b0;
  logic hd;
  logic hbo;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] last_diff = '0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .A      (a),
    .B      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  half_subtractor u_hs (
    .A      (ha),
    .B      (hb),
    .diff   (hd),
    .borrow (hbo)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got %b want 0", done);
    end
    checks++;
    if (diff !== 8'h00) begin
      errors++;
      $display("FAIL reset_diff got %h want 00", diff);
    end
    checks++;
    if (borrow !== 1'b0) begin
      errors++;
      $display("FAIL reset_borrow got %b want 0", borrow);
    end
  endtask

  task automatic test_half_sub();
    logic [3:0] td;
    logic [3:0] tbr;
    logic [1:0] v;
    td  = 4'b0110;
    tbr = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      v  = 2'(i);
      ha = v[1];
      hb = v[0];
      #1;
      checks++;
      if (hd !== td[i] || hbo !== tbr[i]) begin
        errors++;
        $display("FAIL hs_vec%0d got d=%b b=%b want d=%b b=%b",
                 i, hd, hbo, td[i], tbr[i]);
      end
    end
  endtask

  // Call at #1 after an edge with the DUT in IDLE.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ed, input logic eb,
                        input string nm);
    int   k;
    int   bcnt;
    logic held_ok;
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~av;
    b = ~bv;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_rise got %b want 1", nm, busy);
    end
    bcnt = 1;
    held_ok = 1'b1;
    k = 0;
    while (done !== 1'b1 && k < 3 * W) begin
      if (diff !== last_diff) held_ok = 1'b0;
      @(posedge clk);
      #1;
      k++;
      if (busy === 1'b1) bcnt++;
    end
    checks++;
    if (k != W) begin
      errors++;
      $display("FAIL %s latency got %0d edges want %0d", nm, k, W);
    end
    checks++;
    if (!held_ok) begin
      errors++;
      $display("FAIL %s hold_prev got changed want %h", nm, last_diff);
    end
    checks++;
    if (diff !== ed || borrow !== eb) begin
      errors++;
      $display("FAIL %s result got %h/%b want %h/%b",
               nm, diff, borrow, ed, eb);
    end
    @(posedge clk);
    #1;
    if (busy === 1'b1) bcnt++;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s end got done=%b busy=%b want 0/0", nm, done, busy);
    end
    checks++;
    if (bcnt != W + 1) begin
      errors++;
      $display("FAIL %s busy_len got %0d want %0d", nm, bcnt, W + 1);
    end
    checks++;
    if (diff !== ed || borrow !== eb) begin
      errors++;
      $display("FAIL %s held got %h/%b want %h/%b",
               nm, diff, borrow, ed, eb);
    end
    last_diff = ed;
  endtask

  task automatic test_basic();
    run_op(8'd9, 8'd5, 8'd4, 1'b0, "9m5");
    run_op(8'd5, 8'd9, 8'hFC, 1'b1, "5m9");
    run_op(8'hFF, 8'h01, 8'hFE, 1'b0, "FFm1");
  endtask

  task automatic test_edges();
    run_op(8'd0, 8'd0, 8'd0, 1'b0, "0m0");
    run_op(8'd0, 8'hFF, 8'h01, 1'b1, "0mFF");
  endtask

  task automatic test_start_held();
    int dcnt;
    int k;
    a = 8'd3;
    b = 8'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 8'hAA;
    dcnt = 0;
    for (int i = 1; i <= W + 1; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        dcnt++;
        checks++;
        if (diff !== 8'd2 || borrow !== 1'b0) begin
          errors++;
          $display("FAIL held_start result got %h/%b want 02/0",
                   diff, borrow);
        end
      end
    end
    checks++;
    if (dcnt != 1) begin
      errors++;
      $display("FAIL held_start done_count got %0d want 1", dcnt);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL held_start idle_gap got busy=%b want 0", busy);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL held_start reaccept got busy=%b want 1", busy);
    end
    k = 0;
    while (done !== 1'b1 && k < 3 * W) begin
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if (done !== 1'b1 || diff !== 8'hA9 || borrow !== 1'b0) begin
      errors++;
      $display("FAIL held_start second got done=%b %h/%b want 1 A9/0",
               done, diff, borrow);
    end
    @(posedge clk);
    #1;
    last_diff = 8'hA9;
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    a = 8'd50;
    b = 8'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, diff, borrow} !== '0) begin
      errors++;
      $display("FAIL reset_mid outputs got %b %b %h %b want 0 0 00 0",
               busy, done, diff, borrow);
    end
    saw_done = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (W + 2) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL reset_mid no_done got activity want none");
    end
    last_diff = '0;
    run_op(8'd20, 8'd7, 8'd13, 1'b0, "20m7");
  endtask

  task automatic test_back_to_back();
    run_op(8'd100, 8'd1, 8'd99, 1'b0, "100m1");
    run_op(8'd1, 8'd2, 8'hFF, 1'b1, "1m2");
  endtask

  initial begin
    #2;
    test_reset();
    test_half_sub();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_basic();
    test_edges();
    test_start_held();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
